// File: rtl/rvv_rt_xrf_if.sv
// Scalar-writeback retire bundle: NUM_SLOTS retire lanes in, one regfile write port out.
// The master drives the retire lanes and the sink ready; the slave is the arbiter.
interface rvv_rt_xrf_if #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32
);
    logic [NUM_SLOTS-1:0]        rt_valid_i;
    logic [NUM_SLOTS*ADDR_W-1:0] rt_addr_i;
    logic [NUM_SLOTS*DATA_W-1:0] rt_data_i;
    logic [NUM_SLOTS-1:0]        rt_ready_o;
    logic                        async_rd_valid_o;
    logic [ADDR_W-1:0]           async_rd_addr_o;
    logic [DATA_W-1:0]           async_rd_data_o;
    logic                        async_rd_ready_i;

    modport master (
        output rt_valid_i, rt_addr_i, rt_data_i, async_rd_ready_i,
        input  rt_ready_o, async_rd_valid_o, async_rd_addr_o, async_rd_data_o
    );

    modport slave (
        input  rt_valid_i, rt_addr_i, rt_data_i, async_rd_ready_i,
        output rt_ready_o, async_rd_valid_o, async_rd_addr_o, async_rd_data_o
    );
endinterface

// File: rtl/rvv_rt_xrf_arbiter.sv
// Funnels NUM_SLOTS retire lanes into the single scalar-regfile write port via an in-order FIFO.
// Define RVV_RT_XRF_BYPASS_EN to let slot 0 flow straight through when the FIFO is empty.
module rvv_rt_xrf_arbiter #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    rvv_rt_xrf_if.slave                xrf,
    output logic [$clog2(DEPTH+1)-1:0] fill_level_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    logic [NUM_SLOTS-1:0] ready_w, accept_w, we_w;
    logic [PW-1:0]        widx_w [NUM_SLOTS];
    logic                 byp_w, byp_take_w, pop_w;
    logic                 out_valid_w;
    logic [ADDR_W-1:0]    out_addr_w;
    logic [DATA_W-1:0]    out_data_w;
    int unsigned          free_w, n_push, idx;

    always_comb begin
        // Credit comes from the registered count only, so the sink ready never reaches rt_ready_o.
        free_w  = DEPTH - 32'(count_q);
        ready_w = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++)
            ready_w[i] = !rst && (i < free_w);
        accept_w = xrf.rt_valid_i & ready_w;

`ifdef RVV_RT_XRF_BYPASS_EN
        byp_w = !rst && (count_q == '0);
`else
        byp_w = 1'b0;
`endif

        out_valid_w = 1'b0;
        out_addr_w  = '0;
        out_data_w  = '0;
        if (byp_w) begin
            out_valid_w = xrf.rt_valid_i[0];
            if (out_valid_w) begin
                out_addr_w = xrf.rt_addr_i[ADDR_W-1:0];
                out_data_w = xrf.rt_data_i[DATA_W-1:0];
            end
        end else if (count_q != '0) begin
            out_valid_w              = 1'b1;
            {out_addr_w, out_data_w} = mem_q[rd_ptr_q];
        end

        byp_take_w = byp_w && out_valid_w && xrf.async_rd_ready_i;
        pop_w      = !byp_w && out_valid_w && xrf.async_rd_ready_i;

        // Compact accepted slots in ascending order starting at wr_ptr.
        n_push = 0;
        we_w   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            widx_w[i] = '0;
            if (accept_w[i] && !(i == 0 && byp_take_w)) begin
                idx = 32'(wr_ptr_q) + n_push;
                if (idx >= DEPTH) idx = idx - DEPTH;
                we_w[i]   = 1'b1;
                widx_w[i] = PW'(idx);
                n_push    = n_push + 1;
            end
        end

        idx = 32'(wr_ptr_q) + n_push;
        if (idx >= DEPTH) idx = idx - DEPTH;
        wr_ptr_d = PW'(idx);

        idx = 32'(rd_ptr_q) + 1;
        if (idx >= DEPTH) idx = idx - DEPTH;
        rd_ptr_d = pop_w ? PW'(idx) : rd_ptr_q;

        count_d = CW'(32'(count_q) + n_push - (pop_w ? 32'd1 : 32'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++)
            if (we_w[i])
                mem_q[widx_w[i]] <= {xrf.rt_addr_i[i*ADDR_W +: ADDR_W],
                                     xrf.rt_data_i[i*DATA_W +: DATA_W]};
    end

    assign xrf.rt_ready_o       = ready_w;
    assign xrf.async_rd_valid_o = out_valid_w;
    assign xrf.async_rd_addr_o  = out_addr_w;
    assign xrf.async_rd_data_o  = out_data_w;
    assign fill_level_o         = count_q;
endmodule

// File: tb/tb_rvv_rt_xrf_arbiter.sv
// Randomized self-checking bench for rvv_rt_xrf_arbiter against a queue-based reference model.
// Build with RVV_RT_XRF_BYPASS_EN defined to check the bypass variant.
module tb_rvv_rt_xrf_arbiter;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     fill;
    int unsigned    n_checks = 0;
    int unsigned    n_errors = 0;
    logic [AW+DW-1:0] q [$];

    rvv_rt_xrf_if #(.NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW)) xif ();

    rvv_rt_xrf_arbiter #(.NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .xrf          (xif),
        .fill_level_o (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare outputs with the model, then advance the model across the coming clock edge.
    task automatic eval_cycle();
        logic [3:0]       v;
        logic [3:0]       exp_rdy;
        logic             byp, ev, popped;
        logic [AW+DW-1:0] eo;
        int unsigned      fr;
        v   = xif.rt_valid_i;
        fr  = DP - q.size();
        for (int i = 0; i < 4; i++) exp_rdy[i] = (i < fr);
        byp = 1'b0;
`ifdef RVV_RT_XRF_BYPASS_EN
        byp = (q.size() == 0);
`endif
        ev = 1'b0;
        eo = '0;
        if (byp) begin
            ev = v[0];
            if (ev) eo = {xif.rt_addr_i[AW-1:0], xif.rt_data_i[DW-1:0]};
        end else if (q.size() != 0) begin
            ev = 1'b1;
            eo = q[0];
        end
        check("rt_ready", 64'(xif.rt_ready_o), 64'(exp_rdy));
        check("fill_level", 64'(fill), 64'(q.size()));
        check("fill_bound", 64'(fill > 4'(DP)), 64'd0);
        check("rd_valid", 64'(xif.async_rd_valid_o), 64'(ev));
        check("rd_addr", 64'(xif.async_rd_addr_o), 64'(eo[AW+DW-1:DW]));
        check("rd_data", 64'(xif.async_rd_data_o), 64'(eo[DW-1:0]));
        popped = ev && xif.async_rd_ready_i;
        if (popped && !byp) void'(q.pop_front());
        for (int i = 0; i < 4; i++)
            if (v[i] && exp_rdy[i] && !(i == 0 && byp && popped))
                q.push_back({xif.rt_addr_i[i*AW +: AW], xif.rt_data_i[i*DW +: DW]});
    endtask

    task automatic drive(input logic [3:0] v, input logic [19:0] addrs, input logic rdy);
        xif.rt_valid_i = v;
        xif.rt_addr_i  = addrs;
        for (int i = 0; i < 4; i++) xif.rt_data_i[i*DW +: DW] = $urandom;
        xif.async_rd_ready_i = rdy;
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && q.size() != 0; k++) drive(4'b0000, 20'h0, 1'b1);
        check("drained", 64'(fill), 64'd0);
    endtask

    logic [19:0] ra;

    initial begin
        xif.rt_valid_i       = '0;
        xif.rt_addr_i        = '0;
        xif.rt_data_i        = '0;
        xif.async_rd_ready_i = 1'b0;
        #1;
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_valid", 64'(xif.async_rd_valid_o), 64'd0);
        check("rst_ready", 64'(xif.rt_ready_o), 64'd0);
        check("rst_addr", 64'(xif.async_rd_addr_o), 64'd0);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle
        drive(4'b0000, 20'h0, 1'b1);
        drive(4'b0000, 20'h0, 1'b0);

        // Burst of four in order
        drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1);
        drain();

        // Sparse pattern: slots 1 and 3
        drive(4'b1010, {5'd9, 5'd0, 5'd7, 5'd0}, 1'b0);
        check("sparse_fill", 64'(fill), 64'd2);
        drain();

        // Fill to full with the sink stalled
        drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
        drive(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0);
        check("full_ready", 64'(xif.rt_ready_o), 64'd0);
        drive(4'b1111, {5'd12, 5'd11, 5'd10, 5'd13}, 1'b0);
        drain();

        // Level 6: two slots of credit; slot 2 alone must be refused
        drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
        drive(4'b0011, {5'd0, 5'd0, 5'd6, 5'd5}, 1'b0);
        check("six_ready", 64'(xif.rt_ready_o), 64'b0011);
        drive(4'b0100, {5'd0, 5'd21, 5'd0, 5'd0}, 1'b0);
        check("six_hold", 64'(fill), 64'd6);

        // Backpressure: outputs held, then a single pop
        drive(4'b0000, 20'h0, 1'b0);
        drive(4'b0000, 20'h0, 1'b0);
        drive(4'b0000, 20'h0, 1'b1);
        check("bp_pop", 64'(fill), 64'd5);

        // Random wrap with simultaneous push/pop
        for (int c = 0; c < 40; c++) begin
            ra = 20'($urandom);
            drive(4'($urandom), ra, 1'($urandom));
        end
        drain();

        // Mid-stream reset with five entries buffered
        drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
        drive(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, 1'b0);
        check("pre_rst_fill", 64'(fill), 64'd5);
        xif.rt_valid_i       = 4'b1111;
        xif.async_rd_ready_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_fill", 64'(fill), 64'd0);
        check("mid_rst_valid", 64'(xif.async_rd_valid_o), 64'd0);
        check("mid_rst_ready", 64'(xif.rt_ready_o), 64'd0);
        @(posedge clk);
        #1;
        check("rst_edge_fill", 64'(fill), 64'd0);
        rst = 1'b0;
        q.delete();
        drive(4'b0000, 20'h0, 1'b1);
        drive(4'b0011, {5'd0, 5'd0, 5'd17, 5'd16}, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rvv_rt_xrf_arbiter.md
Name: rvv_rt_xrf_arbiter

Overview:
- Receiving end of the vector backend's scalar-writeback retire interface (rt_xrf, NUM_SLOTS lanes per cycle).
- Funnels all lanes into the single async scalar-regfile write port (async_rd_*). This replaces the slot-0-only tie-off.
- Buffers retired writebacks in a multi-in/single-out FIFO.
- Preserves program order: lower slot index is older within a cycle; earlier cycles are older than later cycles.

Parameters:
NUM_SLOTS, 4, number of retire lanes (matches `NUM_RT_UOP)
ADDR_W, 5, scalar register index width
DATA_W, 32, scalar register data width
DEPTH, 8, FIFO entries; legal range NUM_SLOTS..64

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rt_valid_i  in  NUM_SLOTS  per-slot writeback valid
rt_addr_i  in  NUM_SLOTS*ADDR_W  per-slot destination register (rt_index)
rt_data_i  in  NUM_SLOTS*DATA_W  per-slot writeback data (rt_data)
rt_ready_o  out  NUM_SLOTS  per-slot ready
async_rd_valid_o  out  1  writeback valid to scalar regfile
async_rd_addr_o  out  ADDR_W  writeback register index
async_rd_data_o  out  DATA_W  writeback data
async_rd_ready_i  in  1  scalar regfile accepts
fill_level_o  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Reset (asynchronous, active-high) clears rd_ptr, wr_ptr and count, with immediate effect.
- Reset values: async_rd_valid_o=0, fill_level_o=0, rt_ready_o=0 while rst is asserted. Addr/data outputs are don't-care while valid=0; drive them to 0.
- Reset mid-stream discards all buffered entries. No handshake completes in a cycle where rst=1.
- Free space: free = DEPTH - count, computed from the registered count only. Same-cycle pops give no credit, so there is no combinational path from async_rd_ready_i to rt_ready_o.
- Ready rule: rt_ready_o[i] = (i < free). Ready is independent of rt_valid_i.
- Push:
  - Every slot with valid&ready is accepted.
  - Accepted slots are compacted in ascending slot order into consecutive entries starting at wr_ptr.
  - Sparse valid patterns are legal, e.g. 0b0101 writes slot0 then slot2.
- Pop:
  - async_rd_valid_o = (count != 0).
  - addr/data = entry[rd_ptr].
  - On valid&ready, rd_ptr advances by 1.
  - Output holds stable while valid && !ready.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap is by explicit compare.
- Next count = count + pushes - pop. A simultaneous push and pop is allowed at any level, including full (free=0: no push, pop proceeds) and empty (no pop).
- Latency: an entry written in cycle t is visible on async_rd_* at cycle t+1 at the earliest.
- Throughput: up to NUM_SLOTS pushes per cycle; exactly 1 pop per cycle when the sink is ready.
- Ordering: the pop sequence equals the accept sequence. Writes to the same register are never reordered.

Optional Feature:
- Macro: RVV_RT_XRF_BYPASS_EN.
- Enabled: when count==0, async_rd_valid_o = rt_valid_i[0] and addr/data come combinationally from slot 0.
  - If async_rd_ready_i=1, slot 0 is consumed directly and only the other accepted slots are pushed.
  - Otherwise slot 0 is pushed as normal.
  - Zero-cycle latency on an empty queue.
- Disabled: the 1-cycle-minimum registered path described in Behaviour.

Test Plan:
- Reset then idle: all outputs 0; assert rst mid-stream with count=5 -> fill_level_o=0 and async_rd_valid_o=0 immediately.
- Burst: valid=0b1111 with addrs 1,2,3,4 and async_rd_ready_i=1 -> pops in order 1,2,3,4 on 4 consecutive cycles starting t+1 (t with BYPASS_EN).
- Sparse: valid=0b1010 with addrs 7,9 -> exactly two entries, popped 7 then 9; fill_level_o=2 after push.
- Full: hold async_rd_ready_i=0 and push 8 entries -> rt_ready_o=0000 at count=8; count=6 gives rt_ready_o=0011; a valid on slot 2 with ready=0 is not accepted.
- Wrap plus simultaneous push/pop: 40 random cycles with random ready -> scoreboard matches accept order exactly; fill_level_o never exceeds 8.
- Backpressure: valid held and ready=0 for 3 cycles -> addr/data stable, then one pop on the ready cycle.
